// File: rtl/shift_arbiter_if.sv
// Handshake bundle for shift_arbiter: two requester ports and one response port.
// slave = arbiter side, master = requesters plus the response consumer.
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-port arbitrated 32-bit shifter/rotator with a one-entry result register.
// Ports: clk, clr (async active-low reset), bus (shift_arbiter_if.slave).
// Macro SHIFT_ARB_RR_EN selects round-robin; default is fixed priority (req0).
module shift_arbiter (
  input logic            clk,
  input logic            clr,
  shift_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic        rsp_id_q;
  logic        rsp_id_d;
  logic [31:0] result_q;
  logic [31:0] result_d;
  logic        err_q;
  logic        err_d;
  logic        idle;
  logic        gnt0;
  logic        gnt1;
  logic [2:0]  op_sel;
  logic [31:0] a_sel;
  logic [31:0] b_sel;

  // Readys are masked while clr is low so nothing is handed over in reset.
  assign idle = (state_q == IDLE) && clr;

`ifdef SHIFT_ARB_RR_EN
  logic last_q;
  logic last_d;

  // On a tie, serve whichever port was not served last.
  assign gnt1 = idle && bus.req1_valid
             && (!bus.req0_valid || !last_q);
  assign last_d = gnt1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      last_q <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_q <= last_d;
    end
  end
`else
  assign gnt1 = idle && bus.req1_valid && !bus.req0_valid;
`endif

  assign gnt0 = idle && bus.req0_valid && !gnt1;

  // Returns {err, result}. Rotates double the operand so an
  // amount of 0 never needs a shift by 32.
  function automatic logic [32:0] shift_op(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic        big;
    logic [4:0]  amt;
    logic [63:0] rl;
    logic [63:0] rr;
    logic [31:0] sra;
    big = |b[31:5];
    amt = b[4:0];
    rl  = {a, a} << amt;
    rr  = {a, a} >> amt;
    sra = $signed(a) >>> amt;
    case (op)
      3'b000:  shift_op = {1'b0, big ? 32'd0 : a << amt};
      3'b001:  shift_op = {1'b0, big ? 32'd0 : a >> amt};
      3'b010:  shift_op = {1'b0, big ? {32{a[31]}} : sra};
      3'b011:  shift_op = {1'b0, rl[63:32]};
      3'b100:  shift_op = {1'b0, rr[31:0]};
      default: shift_op = {1'b1, 32'd0};
    endcase
  endfunction

  always_comb begin
    op_sel = bus.req0_op;
    a_sel  = bus.req0_a;
    b_sel  = bus.req0_b;
    if (gnt1) begin
      op_sel = bus.req1_op;
      a_sel  = bus.req1_a;
      b_sel  = bus.req1_b;
    end
    {err_d, result_d} = shift_op(op_sel, a_sel, b_sel);
    rsp_id_d = gnt1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      rsp_id_q <= 1'b0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            state_q  <= BUSY;
            rsp_id_q <= rsp_id_d;
            result_q <= result_d;
            err_q    <= err_d;
          end
        end
        BUSY: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = (state_q == BUSY);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 32 bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clr, input, 1, the asynchronous active-low reset.
REQ-004 For n in {0,1}, the block SHALL have port reqN_valid, input, 1, meaning requester N presents an operation.
REQ-005 For n in {0,1}, the block SHALL have port reqN_ready, output, 1, meaning requester N's operation is accepted this cycle.
REQ-006 For n in {0,1}, the block SHALL have port reqN_op, input, 3, giving the opcode: 000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, others illegal.
REQ-007 For n in {0,1}, the block SHALL have port reqN_a, input, 32, the operand.
REQ-008 For n in {0,1}, the block SHALL have port reqN_b, input, 32, the shift/rotate amount.
REQ-009 The block SHALL have port rsp_valid, output, 1, meaning a result is held.
REQ-010 The block SHALL have port rsp_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port rsp_id, output, 1, giving the index of the requester served.
REQ-012 The block SHALL have port rsp_result, output, 32, the registered result.
REQ-013 The block SHALL have port rsp_err, output, 1, meaning the served opcode was illegal.

Function
REQ-014 The FSM SHALL have two states: IDLE (no result held) and BUSY (result held, rsp_valid=1).
REQ-015 In IDLE, the block SHALL compute the grant combinationally from reqN_valid; reqN_ready=1 only for the granted requester and only in IDLE; both readys SHALL be 0 in BUSY.
REQ-016 At a rising edge with IDLE and a granted valid, the block SHALL register the result of the granted request, set rsp_id, go to BUSY, and update the last-grant pointer.
REQ-017 Latency SHALL be 1 cycle: rsp_valid rises the cycle after acceptance; maximum throughput SHALL be one operation per 2 cycles.
REQ-018 In BUSY, rsp_result, rsp_id and rsp_err SHALL remain stable until the edge where rsp_ready=1, which returns the FSM to IDLE; there SHALL be no same-cycle re-accept.
REQ-019 SHL and SHR SHALL shift in zeros; for b>=32 the result SHALL be 0.
REQ-020 SHRA SHALL replicate a[31]; for b>=32 the result SHALL be 32 copies of a[31].
REQ-021 ROL and ROR SHALL use b[4:0] only; an amount of 0 SHALL return a unchanged, with no shift-by-32 artifact.
REQ-022 An illegal opcode SHALL be accepted normally with rsp_result=0 and rsp_err=1; legal opcodes SHALL give rsp_err=0.
REQ-023 Requests with reqN_valid=0 SHALL never be granted; a requester may drop valid before grant without effect.

Reset
REQ-024 When clr=0, the block SHALL asynchronously go to IDLE with rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, and last-grant pointer=1, so that port 0 wins the first tie.
REQ-025 Reset asserted in BUSY SHALL discard the held result; no response SHALL be produced for it after release.
REQ-026 Reset release SHALL take effect at the next rising clk edge; no request SHALL be accepted while clr=0.

Configuration
REQ-027 With SHIFT_ARB_RR_EN defined, the block SHALL arbitrate round-robin: when both requesters are valid, it grants the requester not served last; when only one is valid, it grants that requester.
REQ-028 Without SHIFT_ARB_RR_EN, the block SHALL use fixed priority: requester 0 always wins ties; the pointer register MAY be omitted.

Verification
REQ-029 The bench SHALL cover: req0 SHL a=0x0000_0001 b=4 -> next cycle rsp_valid=1, rsp_result=0x0000_0010, rsp_id=0, rsp_err=0.
REQ-030 The bench SHALL cover: SHRA a=0x8000_0000 b=40, and ROR a=0x0000_0001 b=33 -> results 0xFFFF_FFFF and 0x8000_0000.
REQ-031 The bench SHALL cover: ROL a=0x1234_5678 b=0, and op=111 -> results 0x1234_5678 (err=0) and 0x0000_0000 (err=1).
REQ-032 The bench SHALL cover: both requesters valid continuously with rsp_ready=1 -> RR_EN gives rsp_id 0,1,0,1; no RR_EN gives rsp_id 0,0,0,0.
REQ-033 The bench SHALL cover: rsp_ready=0 for 5 cycles in BUSY -> outputs stable, both reqN_ready=0; rsp_ready=1 -> IDLE next edge.
REQ-034 The bench SHALL cover: clr pulsed low mid-BUSY -> rsp_valid=0 immediately (asynchronous), no stale response, and port 0 wins the next tie.
